// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-flop synchroniser, baud counter and one-entry holding register.
// Optional UART_RX_MAJORITY_EN: 2-of-3 majority vote around each mid-bit sample.
module uart_rx #(
  parameter int CLOCK_FREQ = 64_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rxd,
  output logic [7:0] uart_rx_data,
  output logic       uart_rx_valid,
  input  logic       uart_rx_ready,
  output logic       uart_rx_busy,
  output logic       uart_rx_frame_err,
  output logic       uart_rx_overrun
);

  localparam int CPB = (CLOCK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam logic [15:0] L_BIT = 16'(CPB - 1);
`ifdef UART_RX_MAJORITY_EN
  // Decide one clock after mid so the vote window is mid-1, mid, mid+1.
  localparam logic [15:0] L_HALF = 16'(CPB / 2);
`else
  localparam logic [15:0] L_HALF = 16'(CPB / 2 - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT
  } state_t;

  state_t      r_state;
  state_t      w_state_n;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_n;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_n;
  logic [2:0]  r_bit;
  logic [2:0]  w_bit_n;
  logic        r_sync1;
  logic        r_sync2;
  logic        w_rx;
  logic        w_smp;
  logic        w_tick;
  logic        w_deliver;
  logic        w_ferr;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_ferr;
  logic        r_ovr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_rxd;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx = r_sync2;

`ifdef UART_RX_MAJORITY_EN
  logic r_d1;
  logic r_d2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d1 <= 1'b1;
      r_d2 <= 1'b1;
    end else begin
      r_d1 <= w_rx;
      r_d2 <= r_d1;
    end
  end

  assign w_smp = (w_rx & r_d1) | (w_rx & r_d2) | (r_d1 & r_d2);
`else
  assign w_smp = w_rx;
`endif

  assign w_tick = (r_cnt == 16'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 16'd0;
      r_shift <= 8'd0;
      r_bit   <= 3'd0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_shift <= w_shift_n;
      r_bit   <= w_bit_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = w_tick ? r_cnt : r_cnt - 16'd1;
    w_shift_n = r_shift;
    w_bit_n   = r_bit;
    w_deliver = 1'b0;
    w_ferr    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_rx) begin
          w_cnt_n   = L_HALF;
          w_state_n = S_START;
        end
      end
      S_START: begin
        if (w_tick) begin
          if (!w_smp) begin
            w_cnt_n   = L_BIT;
            w_bit_n   = 3'd0;
            w_state_n = S_DATA;
          end else begin
            w_state_n = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_shift_n = {w_smp, r_shift[7:1]};
          w_cnt_n   = L_BIT;
          w_bit_n   = r_bit + 3'd1;
          if (r_bit == 3'd7) begin
            w_state_n = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (w_smp) begin
            w_deliver = 1'b1;
            w_state_n = S_IDLE;
          end else begin
            w_ferr    = 1'b1;
            w_state_n = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (w_rx) begin
          w_state_n = S_IDLE;
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= 8'd0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_ferr;
      r_ovr  <= w_deliver & r_valid & ~uart_rx_ready;
      if (w_deliver && (!r_valid || uart_rx_ready)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (!w_deliver && r_valid && uart_rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign uart_rx_data      = r_data;
  assign uart_rx_valid     = r_valid;
  assign uart_rx_busy      = (r_state != S_IDLE);
  assign uart_rx_frame_err = r_ferr;
  assign uart_rx_overrun   = r_ovr;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 8 clocks per bit.
// Table vectors, directed corner sequences and random frames vs a queue model.
module tb_uart_rx;

  logic       clk;
  logic       rst_n;
  logic       rxd;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       busy;
  logic       ferr;
  logic       ovr;

  uart_rx #(
    .CLOCK_FREQ(1_000_000),
    .BAUD_RATE (125_000)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .uart_rxd         (rxd),
    .uart_rx_data     (data),
    .uart_rx_valid    (valid),
    .uart_rx_ready    (ready),
    .uart_rx_busy     (busy),
    .uart_rx_frame_err(ferr),
    .uart_rx_overrun  (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_err;
  int cyc;

  // monitor-owned counters; tests use deltas
  logic [7:0] acc_q[$];
  int n_vcyc;
  int n_ferr;
  int n_ovr;
  int n_busy;
  int t_vrise;
  logic pv;

  initial begin
    n_vcyc  = 0;
    n_ferr  = 0;
    n_ovr   = 0;
    n_busy  = 0;
    t_vrise = 0;
    pv      = 1'b0;
    cyc     = 0;
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid) n_vcyc++;
      if (valid && !pv) t_vrise = cyc;
      if (valid && ready) acc_q.push_back(data);
      if (ferr) n_ferr++;
      if (ovr) n_ovr++;
      if (busy) n_busy++;
      pv = valid;
    end else begin
      pv = 1'b0;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic sb);
    rxd = 1'b0;
    tick(8);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(8);
    end
    rxd = sb;
    tick(8);
    rxd = 1'b1;
  endtask

  typedef struct {
    logic [7:0] din;
    logic       stop;
    int         exp_acc;
    logic [7:0] exp_data;
    int         exp_ferr;
  } vec_t;

  vec_t tv[6];
  logic [7:0] exp_q[$];
  int b_acc, b_fe, b_ov, b_vc, b_bs, t0, lat, nf, gap;
  logic [7:0] rb;
  logic rs;
  logic [7:0] glitch_exp;

  initial begin
    n_chk = 0;
    n_err = 0;
    tv[0] = '{8'h00, 1'b1, 1, 8'h00, 0};
    tv[1] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
    tv[2] = '{8'h80, 1'b1, 1, 8'h80, 0};
    tv[3] = '{8'h01, 1'b1, 1, 8'h01, 0};
    tv[4] = '{8'h3C, 1'b0, 0, 8'h00, 1};
    tv[5] = '{8'hE7, 1'b1, 1, 8'hE7, 0};

    rst_n = 1'b0;
    rxd   = 1'b1;
    ready = 1'b1;
    tick(3);
    chk("rst_data", data, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ferr", ferr, 0);
    chk("rst_ovr", ovr, 0);
    rst_n = 1'b1;
    tick(4);

    // single 0x55 with ready high, latency bound
    b_acc = acc_q.size(); b_vc = n_vcyc; b_fe = n_ferr; b_ov = n_ovr;
    t0 = cyc;
    fork
      send_frame(8'h55, 1'b1);
      begin
        tick(40);
        chk("t1_busy_mid", busy, 1);
      end
    join
    tick(16);
    chk("t1_acc", acc_q.size() - b_acc, 1);
    if (acc_q.size() > b_acc) chk("t1_data", acc_q[$], 8'h55);
    chk("t1_vcyc", n_vcyc - b_vc, 1);
    chk("t1_ferr", n_ferr - b_fe, 0);
    chk("t1_ovr", n_ovr - b_ov, 0);
    chk("t1_busy_end", busy, 0);
    lat = t_vrise - t0;
    chk("t1_latency", (lat >= 72 && lat <= 80) ? 1 : 0, 1);

    // back-to-back with ready low: overrun keeps first byte
    ready = 1'b0;
    b_acc = acc_q.size(); b_fe = n_ferr; b_ov = n_ovr;
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    tick(20);
    chk("t2_valid", valid, 1);
    chk("t2_data", data, 8'hA3);
    chk("t2_ovr", n_ovr - b_ov, 1);
    chk("t2_ferr", n_ferr - b_fe, 0);
    ready = 1'b1;
    tick(1);
    chk("t2_clear", valid, 0);
    chk("t2_acc", acc_q.size() - b_acc, 1);
    if (acc_q.size() > b_acc) chk("t2_accd", acc_q[$], 8'hA3);

    // bad stop then stuck-low line
    b_acc = acc_q.size(); b_fe = n_ferr; b_vc = n_vcyc;
    send_frame(8'h42, 1'b0);
    rxd = 1'b0;
    tick(160);
    chk("t3_ferr", n_ferr - b_fe, 1);
    chk("t3_novalid", n_vcyc - b_vc, 0);
    chk("t3_busy_low", busy, 1);
    rxd = 1'b1;
    tick(4);
    chk("t3_busy_hi", busy, 0);
    send_frame(8'h81, 1'b1);
    tick(16);
    chk("t3_acc", acc_q.size() - b_acc, 1);
    if (acc_q.size() > b_acc) chk("t3_data", acc_q[$], 8'h81);

    // short glitch: false start
    b_vc = n_vcyc; b_fe = n_ferr; b_bs = n_busy;
    rxd = 1'b0;
    tick(2);
    rxd = 1'b1;
    tick(12);
    chk("t4_busy_seen", (n_busy > b_bs) ? 1 : 0, 1);
    chk("t4_busy", busy, 0);
    chk("t4_novalid", n_vcyc - b_vc, 0);
    chk("t4_ferr", n_ferr - b_fe, 0);

    // reset mid-frame
    rxd = 1'b0;
    tick(8);
    for (int i = 0; i < 4; i++) begin
      rb = 8'h99;
      rxd = rb[i];
      tick(8);
    end
    chk("t5_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_valid", valid, 0);
    chk("t5_data", data, 0);
    chk("t5_ferr", ferr, 0);
    chk("t5_ovr", ovr, 0);
    rxd = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(4);
    b_acc = acc_q.size();
    send_frame(8'hC6, 1'b1);
    tick(16);
    chk("t5_acc", acc_q.size() - b_acc, 1);
    if (acc_q.size() > b_acc) chk("t5_rx", acc_q[$], 8'hC6);

    // one-clock high glitch at mid of bit 2
`ifdef UART_RX_MAJORITY_EN
    glitch_exp = 8'h00;
`else
    glitch_exp = 8'h04;
`endif
    b_acc = acc_q.size();
    for (int c = 0; c < 80; c++) begin
      rxd = (c < 8) ? 1'b0 : (c >= 72) ? 1'b1 : (c == 28);
      tick(1);
    end
    rxd = 1'b1;
    tick(16);
    chk("t6_acc", acc_q.size() - b_acc, 1);
    if (acc_q.size() > b_acc) chk("t6_data", acc_q[$], glitch_exp);

    // table vectors
    for (int i = 0; i < 6; i++) begin
      b_acc = acc_q.size(); b_fe = n_ferr; b_ov = n_ovr;
      send_frame(tv[i].din, tv[i].stop);
      tick(20);
      chk($sformatf("tv%0d_acc", i), acc_q.size() - b_acc, tv[i].exp_acc);
      if (tv[i].exp_acc > 0 && acc_q.size() > b_acc)
        chk($sformatf("tv%0d_data", i), acc_q[$], tv[i].exp_data);
      chk($sformatf("tv%0d_ferr", i), n_ferr - b_fe, tv[i].exp_ferr);
      chk($sformatf("tv%0d_ovr", i), n_ovr - b_ov, 0);
      chk($sformatf("tv%0d_busy", i), busy, 0);
    end

    // random frames: model is the list of good-stop bytes in order
    b_acc = acc_q.size(); b_fe = n_ferr; b_ov = n_ovr;
    nf = 0;
    for (int k = 0; k < 25; k++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 9) != 0);
      send_frame(rb, rs);
      if (rs) begin
        exp_q.push_back(rb);
        gap = $urandom_range(0, 12);
      end else begin
        nf++;
        gap = $urandom_range(4, 12);
      end
      if (gap > 0) tick(gap);
    end
    tick(30);
    chk("rnd_count", acc_q.size() - b_acc, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (b_acc + i < acc_q.size())
        chk($sformatf("rnd_byte%0d", i), acc_q[b_acc + i], exp_q[i]);
    end
    chk("rnd_ferr", n_ferr - b_fe, nf);
    chk("rnd_ovr", n_ovr - b_ov, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
